// File: rtl/uart_frame_loader.sv
// Assembles SYNC-framed, optionally checksummed payloads from a received byte stream and
// publishes each good frame as a flat bus with a one-cycle commit strobe.
module uart_frame_loader #(
    parameter int unsigned FRAME_BYTES    = 34,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter bit          CHECKSUM_EN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [8*FRAME_BYTES-1:0] params,
    output logic                     params_valid,
    output logic                     frame_error,
    output logic                     busy,
    output logic [7:0]               err_count
);

    localparam int unsigned IdxW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned PW   = 8 * FRAME_BYTES;

    typedef enum logic [1:0] {StIdle, StPayload, StCsum} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   shadow_q, shadow_d;
    logic [PW-1:0]   params_q, params_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      err_q, err_d;
    logic [7:0]      csum;
    logic            pv_q, pv_d;
    logic            fe_q, fe_d;
    logic            timeout;

    if (TIMEOUT_CYCLES > 0) begin : g_timer
        localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
        logic [TmrW-1:0] timer_q;

        // A byte on the expiry cycle wins over the abort.
        assign timeout = (state_q != StIdle) && !rx_valid &&
                         (timer_q == TmrW'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                timer_q <= '0;
            end else if (state_q == StIdle || rx_valid || timeout) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end else begin : g_no_timer
        assign timeout = 1'b0;
    end

    assign csum = sum_q + rx_data;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        params_d = params_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        pv_d     = 1'b0;
        fe_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = StPayload;
                    idx_d   = IdxW'(FRAME_BYTES - 1);
                    sum_d   = '0;
                end
            end
            StPayload: begin
                if (rx_valid) begin
                    for (int i = 0; i < int'(FRAME_BYTES); i++) begin
                        if (idx_q == IdxW'(i)) shadow_d[8*i +: 8] = rx_data;
                    end
                    sum_d = csum;
                    if (idx_q == '0) begin
                        if (CHECKSUM_EN) begin
                            state_d = StCsum;
                        end else begin
                            params_d = shadow_d;
                            pv_d     = 1'b1;
                            state_d  = StIdle;
                        end
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                    fe_d    = 1'b1;
                end
            end
            StCsum: begin
                if (rx_valid) begin
                    state_d = StIdle;
                    if (csum == 8'h00) begin
                        params_d = shadow_q;
                        pv_d     = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                    fe_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        err_d = (fe_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            params_q <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            err_q    <= '0;
            pv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            params_q <= params_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            err_q    <= err_d;
            pv_q     <= pv_d;
            fe_q     <= fe_d;
        end
    end

    assign params       = params_q;
    assign params_valid = pv_q;
    assign frame_error  = fe_q;
    assign busy         = (state_q != StIdle);
    assign err_count    = err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench: frame table on a 4-byte checksummed loader, plus timeout, reset,
// saturation and a 1-byte no-checksum instance.
module tb_uart_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sel;
    logic       va, vb;

    assign va = rx_valid & ~sel;
    assign vb = rx_valid & sel;

    logic [31:0] params_a;
    logic        pv_a, fe_a, busy_a;
    logic [7:0]  err_a;
    logic [7:0]  params_b;
    logic        pv_b, fe_b, busy_b;
    logic [7:0]  err_b;

    uart_frame_loader #(
        .FRAME_BYTES(4), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(va),
        .params(params_a), .params_valid(pv_a), .frame_error(fe_a),
        .busy(busy_a), .err_count(err_a)
    );

    uart_frame_loader #(
        .FRAME_BYTES(1), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0), .TIMEOUT_CYCLES(50)
    ) dut1 (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(vb),
        .params(params_b), .params_valid(pv_b), .frame_error(fe_b),
        .busy(busy_b), .err_count(err_b)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Bytes left-aligned: first byte in [63:56]; ends one negedge after the last byte edge.
    task automatic send(input logic [63:0] b, input int n);
        for (int j = 0; j < n; j++) drive_byte(b[63-8*j -: 8]);
        idle(1);
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic [31:0] exp_params;
        logic        exp_pv;
        logic        exp_fe;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64'hA5010203_04F60000, 6, 32'h01020304, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{64'hA5010203_04000000, 6, 32'h01020304, 1'b0, 1'b1, 8'd1};
        vecs[2] = '{64'h1122A5A5_0000005B, 8, 32'hA5000000, 1'b1, 1'b0, 8'd1};
        vecs[3] = '{64'hA5FFFFFF_FF040000, 6, 32'hFFFFFFFF, 1'b1, 1'b0, 8'd1};
        vecs[4] = '{64'hA5102030_40600000, 6, 32'h10203040, 1'b1, 1'b0, 8'd1};
        vecs[5] = '{64'hA5102030_40610000, 6, 32'h10203040, 1'b0, 1'b1, 8'd2};

        rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_params", params_a, 0);
        check("rst_pv", pv_a, 0);
        check("rst_fe", fe_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_err", err_a, 0);
        check("rst_params_b", params_b, 0);
        rstn = 1'b1;

        // FRAME_BYTES=1, no checksum
        sel = 1'b1;
        send(64'hA57E0000_00000000, 2);
        check("b_params", params_b, 8'h7E);
        check("b_pv", pv_b, 1);
        check("b_busy", busy_b, 0);
        idle(1);
        check("b_pv_pulse", pv_b, 0);
        send(64'hA5A50000_00000000, 2);
        check("b_sync_as_data", params_b, 8'hA5);
        check("b_err", err_b, 0);
        check("a_untouched", params_a, 0);
        sel = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].bytes, vecs[i].n);
            check($sformatf("v%0d_params", i), params_a, vecs[i].exp_params);
            check($sformatf("v%0d_pv", i), pv_a, vecs[i].exp_pv);
            check($sformatf("v%0d_fe", i), fe_a, vecs[i].exp_fe);
            check($sformatf("v%0d_busy", i), busy_a, 0);
            check($sformatf("v%0d_err", i), err_a, vecs[i].exp_err);
            idle(1);
            check($sformatf("v%0d_pv_clr", i), pv_a, 0);
            check($sformatf("v%0d_fe_clr", i), fe_a, 0);
        end

        // Timeout abort after 50 idle cycles
        drive_byte(8'hA5); drive_byte(8'h01); drive_byte(8'h02);
        idle(50);
        check("to_pre_fe", fe_a, 0);
        check("to_pre_busy", busy_a, 1);
        idle(1);
        check("to_fe", fe_a, 1);
        check("to_busy", busy_a, 0);
        check("to_err", err_a, 3);
        idle(10);
        check("to_fe_clr", fe_a, 0);
        check("to_params", params_a, 32'h10203040);
        send(64'hA50A0B0C_0DD20000, 6);
        check("after_to_params", params_a, 32'h0A0B0C0D);
        check("after_to_pv", pv_a, 1);

        // Byte lands exactly on the expiry cycle
        drive_byte(8'hA5); drive_byte(8'h01);
        idle(49);
        drive_byte(8'h02);
        idle(1);
        check("exp_busy", busy_a, 1);
        check("exp_fe", fe_a, 0);
        send(64'h0304F600_00000000, 3);
        check("exp_params", params_a, 32'h01020304);
        check("exp_pv", pv_a, 1);
        check("exp_err", err_a, 3);

        // Asynchronous reset mid-payload
        drive_byte(8'hA5); drive_byte(8'h01);
        #2 rstn = 1'b0; rx_valid = 1'b0;
        #1;
        check("ar_params", params_a, 0);
        check("ar_busy", busy_a, 0);
        check("ar_err", err_a, 0);
        check("ar_pv", pv_a, 0);
        check("ar_fe", fe_a, 0);
        check("ar_params_b", params_b, 0);
        @(negedge clk);
        rstn = 1'b1;

        // err_count saturation
        for (int k = 0; k < 300; k++) begin
            send(64'hA5000000_00010000, 6);
            if (k == 253) check("sat_254", err_a, 8'hFE);
        end
        check("sat_fe", fe_a, 1);
        check("sat_err", err_a, 8'hFF);
        check("sat_params", params_a, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
